// File: rtl/wfg_core_regbank_pkg.sv
// Shared constants for the waveform-generator core Wishbone register bank:
// byte offsets, CTRL/STATUS bit positions and the bus-handshake state encoding.
package wfg_core_regbank_pkg;

    localparam int OFS_CTRL     = 'h0;
    localparam int OFS_STATUS   = 'h4;
    localparam int OFS_CFG_BASE = 'h8;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_COMMIT = 1;
    localparam int CTRL_IRQEN  = 2;

    localparam int STAT_PEND = 0;
    localparam int STAT_ERR  = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wfg_core_regbank_bytewr.sv
// Byte-lane merge of one bus word: lanes with sel set take the new data when
// we is high, all other lanes keep the current value.
module wfg_core_regbank_bytewr #(
    parameter int BUSW = 32
) (
    input  logic              we,
    input  logic [BUSW/8-1:0] sel,
    input  logic [BUSW-1:0]   cur,
    input  logic [BUSW-1:0]   wdat,
    output logic [BUSW-1:0]   nxt
);

    for (genvar b = 0; b < BUSW/8; b++) begin : g_lane
        assign nxt[8*b +: 8] = (we && sel[b]) ? wdat[8*b +: 8] : cur[8*b +: 8];
    end

endmodule

// File: rtl/wfg_core_wishbone_regbank.sv
// Wishbone slave register bank: CTRL, STATUS and NCFG shadowed config words that
// are copied to the active outputs on the first core update pulse after a COMMIT.
module wfg_core_wishbone_regbank
    import wfg_core_regbank_pkg::*;
#(
    parameter int BUSW = 32,
    parameter int NCFG = 2
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic                       wbs_stb_i,
    input  logic                       wbs_cyc_i,
    input  logic                       wbs_we_i,
    input  logic [BUSW/8-1:0]          wbs_sel_i,
    input  logic [BUSW-1:0]            wbs_dat_i,
    input  logic [BUSW-1:0]            wbs_adr_i,
    output logic                       wbs_ack_o,
    output logic [BUSW-1:0]            wbs_dat_o,
    input  logic                       update_i,
    output logic                       ctrl_en_q_o,
    output logic [NCFG-1:0][BUSW-1:0]  cfg_q_o,
    output logic                       irq_o
);

    localparam int AW = BUSW - 2;
    localparam logic [AW-1:0] W_CTRL    = AW'(OFS_CTRL >> 2);
    localparam logic [AW-1:0] W_STATUS  = AW'(OFS_STATUS >> 2);
    localparam logic [AW-1:0] W_CFG     = AW'(OFS_CFG_BASE >> 2);
    localparam logic [AW-1:0] W_CFG_END = AW'((OFS_CFG_BASE >> 2) + NCFG);
    localparam logic [BUSW-1:0] CTRL_MASK = (BUSW'(1) << CTRL_EN) | (BUSW'(1) << CTRL_IRQEN);

    wb_state_e state_q, state_d;
    logic      accept;

    logic [AW-1:0] word, cfg_idx;
    logic          ctrl_hit, status_hit, cfg_hit, unmapped;
    logic          wr_acc, err_clr, commit_wr;
    logic          adr_unused;

    logic [BUSW-1:0]            ctrl_q, ctrl_d;
    logic                       pend_q, err_q;
    logic [NCFG-1:0][BUSW-1:0]  shadow_q, shadow_d;
    logic [BUSW-1:0]            rdata;

    // Byte offset within the word is not decoded.
    assign adr_unused = ^wbs_adr_i[1:0];
    assign word       = wbs_adr_i[BUSW-1:2];
    assign cfg_idx    = word - W_CFG;
    assign ctrl_hit   = (word == W_CTRL);
    assign status_hit = (word == W_STATUS);
    assign cfg_hit    = (word >= W_CFG) && (word < W_CFG_END);
    assign unmapped   = !(ctrl_hit || status_hit || cfg_hit);

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wbs_stb_i && wbs_cyc_i) begin
                    accept  = 1'b1;
                    state_d = ST_ACK;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign wbs_ack_o = (state_q == ST_ACK);

    assign wr_acc    = accept && wbs_we_i;
    assign err_clr   = wr_acc && status_hit && wbs_sel_i[0] && wbs_dat_i[STAT_ERR];
    assign commit_wr = wr_acc && ctrl_hit && wbs_sel_i[0] && wbs_dat_i[CTRL_COMMIT];

    wfg_core_regbank_bytewr #(.BUSW(BUSW)) u_ctrl_wr (
        .we   (wr_acc && ctrl_hit),
        .sel  (wbs_sel_i),
        .cur  (ctrl_q),
        .wdat (wbs_dat_i),
        .nxt  (ctrl_d)
    );

    for (genvar k = 0; k < NCFG; k++) begin : g_cfg
        wfg_core_regbank_bytewr #(.BUSW(BUSW)) u_cfg_wr (
            .we   (wr_acc && cfg_hit && (cfg_idx == AW'(k))),
            .sel  (wbs_sel_i),
            .cur  (shadow_q[k]),
            .wdat (wbs_dat_i),
            .nxt  (shadow_d[k])
        );
    end

    // Reads see the shadow copies, so software reads back what it wrote.
    always_comb begin
        rdata = '0;
        if (ctrl_hit) begin
            rdata = ctrl_q;
        end else if (status_hit) begin
            rdata[STAT_PEND] = pend_q;
            rdata[STAT_ERR]  = err_q;
        end else if (cfg_hit) begin
            for (int k = 0; k < NCFG; k++)
                if (cfg_idx == AW'(k)) rdata = shadow_q[k];
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= ST_IDLE;
            wbs_dat_o <= '0;
            ctrl_q    <= '0;
            pend_q    <= 1'b0;
            err_q     <= 1'b0;
            shadow_q  <= '0;
            cfg_q_o   <= '0;
        end else begin
            state_q   <= state_d;
            wbs_dat_o <= (accept && !wbs_we_i) ? rdata : '0;
            ctrl_q    <= ctrl_d & CTRL_MASK;
            shadow_q  <= shadow_d;
            if (accept && unmapped) err_q <= 1'b1;
            else if (err_clr)       err_q <= 1'b0;
            // A COMMIT landing on an update pulse waits for the next pulse.
            if (commit_wr) begin
                pend_q <= 1'b1;
            end else if (pend_q && update_i) begin
                pend_q  <= 1'b0;
                cfg_q_o <= shadow_q;
            end
        end
    end

    assign ctrl_en_q_o = ctrl_q[CTRL_EN];
    assign irq_o       = err_q && ctrl_q[CTRL_IRQEN];

endmodule

// File: tb/tb_wfg_core_wishbone_regbank.sv
// Directed and randomized bus traffic against a register-level model of the bank.
module tb_wfg_core_wishbone_regbank;

    localparam int BUSW = 32;
    localparam int NCFG = 2;

    logic                      wb_clk_i = 1'b0;
    logic                      wb_rst_i = 1'b1;
    logic                      wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
    logic [BUSW/8-1:0]         wbs_sel_i = '0;
    logic [BUSW-1:0]           wbs_dat_i = '0, wbs_adr_i = '0;
    logic                      wbs_ack_o;
    logic [BUSW-1:0]           wbs_dat_o;
    logic                      update_i = 1'b0;
    logic                      ctrl_en_q_o;
    logic [NCFG-1:0][BUSW-1:0] cfg_q_o;
    logic                      irq_o;

    wfg_core_wishbone_regbank #(.BUSW(BUSW), .NCFG(NCFG)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o), .update_i(update_i),
        .ctrl_en_q_o(ctrl_en_q_o), .cfg_q_o(cfg_q_o), .irq_o(irq_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    logic [31:0] m_shadow [NCFG];
    logic [31:0] m_active [NCFG];
    logic        m_en, m_irqen, m_pend, m_err;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NCFG; k++) begin
            m_shadow[k] = '0;
            m_active[k] = '0;
        end
        m_en = 0; m_irqen = 0; m_pend = 0; m_err = 0;
    endtask

    task automatic chk_outputs(input string tag);
        for (int k = 0; k < NCFG; k++) chk({tag, "_cfg"}, cfg_q_o[k], m_active[k]);
        chk({tag, "_irq"}, irq_o, m_err & m_irqen);
        chk({tag, "_en"}, ctrl_en_q_o, m_en);
    endtask

    // One complete bus access; upd raises update_i on the acceptance edge.
    task automatic xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat, input logic upd, output logic [31:0] rd);
        logic [31:0] exp_rd;
        int          w, n;
        w = int'(adr >> 2);
        exp_rd = 0;
        if (!we) begin
            if (w == 0)                     exp_rd = {29'd0, m_irqen, 1'b0, m_en};
            else if (w == 1)                exp_rd = {30'd0, m_err, m_pend};
            else if (w >= 2 && w < 2+NCFG)  exp_rd = m_shadow[w-2];
        end
        @(negedge wb_clk_i);
        wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = we;
        wbs_adr_i = adr; wbs_sel_i = sel; wbs_dat_i = dat; update_i = upd;
        @(negedge wb_clk_i);
        update_i = 0;
        n = 1;
        while (!wbs_ack_o && n < 4) begin
            @(negedge wb_clk_i);
            n++;
        end
        chk("ack", wbs_ack_o, 1'b1);
        rd = wbs_dat_o;
        wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
        // model: commit point first, using pre-access shadow contents
        if (we && w == 0 && sel[0] && dat[1]) m_pend = 1;
        else if (m_pend && upd) begin
            for (int k = 0; k < NCFG; k++) m_active[k] = m_shadow[k];
            m_pend = 0;
        end
        if (w >= 2 && w < 2+NCFG) begin
            if (we) for (int b = 0; b < 4; b++)
                if (sel[b]) m_shadow[w-2][8*b +: 8] = dat[8*b +: 8];
        end else if (w == 0) begin
            if (we && sel[0]) begin m_en = dat[0]; m_irqen = dat[2]; end
        end else if (w == 1) begin
            if (we && sel[0] && dat[1]) m_err = 0;
        end else m_err = 1;
        chk("rdata", rd, exp_rd);
        chk_outputs("xfer");
        @(negedge wb_clk_i);
        chk("ack_single", wbs_ack_o, 1'b0);
        chk("dat_idle", wbs_dat_o, 32'd0);
    endtask

    task automatic upd_pulse();
        @(negedge wb_clk_i);
        update_i = 1;
        @(negedge wb_clk_i);
        update_i = 0;
        if (m_pend) begin
            for (int k = 0; k < NCFG; k++) m_active[k] = m_shadow[k];
            m_pend = 0;
        end
        chk_outputs("upd");
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"}, wbs_ack_o, 1'b0);
        chk({tag, "_dat"}, wbs_dat_o, 32'd0);
        chk({tag, "_cfg"}, cfg_q_o, 64'd0);
        chk({tag, "_en"}, ctrl_en_q_o, 1'b0);
        chk({tag, "_irq"}, irq_o, 1'b0);
    endtask

    initial begin
        logic [31:0] rd;
        int          acks;
        model_reset();
        repeat (3) @(negedge wb_clk_i);
        chk_all_zero("reset");
        wb_rst_i = 0;

        // single write/readback; active stays untouched
        xfer(1, 32'h8, 4'hF, 32'h00123456, 0, rd);
        xfer(0, 32'h8, 4'hF, 32'h0, 0, rd);
        chk("cfg0_rd", rd, 32'h00123456);
        chk("cfg0_inactive", cfg_q_o[0], 32'h0);

        // partial lanes, and sel=0 writes nothing
        xfer(1, 32'hC, 4'h5, 32'hAABBCCDD, 0, rd);
        xfer(0, 32'hC, 4'hF, 32'h0, 0, rd);
        chk("cfg1_sel5", rd, 32'h00BB00DD);
        xfer(1, 32'hD, 4'h0, 32'hFFFFFFFF, 0, rd);
        xfer(0, 32'hE, 4'hF, 32'h0, 0, rd);
        chk("cfg1_sel0", rd, 32'h00BB00DD);

        // commit then update
        xfer(1, 32'h0, 4'hF, 32'h2, 0, rd);
        xfer(0, 32'h4, 4'hF, 32'h0, 0, rd);
        chk("status_pend", rd, 32'h1);
        upd_pulse();
        chk("commit_cfg0", cfg_q_o[0], 32'h00123456);
        chk("commit_cfg1", cfg_q_o[1], 32'h00BB00DD);
        xfer(0, 32'h4, 4'hF, 32'h0, 0, rd);
        chk("status_clear", rd, 32'h0);
        upd_pulse();

        // unmapped read raises ERR, W1C clears it
        xfer(1, 32'h0, 4'h1, 32'h4, 0, rd);
        xfer(0, 32'h40, 4'hF, 32'h0, 0, rd);
        chk("unmapped_rd", rd, 32'h0);
        chk("irq_set", irq_o, 1'b1);
        xfer(1, 32'h4, 4'h1, 32'h2, 0, rd);
        chk("irq_clr", irq_o, 1'b0);

        // COMMIT coincident with update only arms PEND
        xfer(1, 32'h8, 4'hF, 32'hCAFEF00D, 0, rd);
        xfer(1, 32'h0, 4'h1, 32'h2, 1, rd);
        chk("coincide_hold", cfg_q_o[0], 32'h00123456);
        xfer(1, 32'h8, 4'h3, 32'h00001111, 0, rd);
        upd_pulse();
        chk("coincide_commit", cfg_q_o[0], 32'hCAFE1111);

        // held strobe: one ack every two cycles
        @(negedge wb_clk_i);
        wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = 0; wbs_adr_i = 32'h0; wbs_sel_i = 4'hF;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge wb_clk_i);
            if (wbs_ack_o) acks++;
        end
        wbs_stb_i = 0; wbs_cyc_i = 0;
        chk("held_acks", acks, 3);

        // reset during ACK
        xfer(1, 32'h0, 4'h1, 32'h5, 0, rd);
        @(negedge wb_clk_i);
        wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = 0; wbs_adr_i = 32'h0;
        @(negedge wb_clk_i);
        chk("ack_before_rst", wbs_ack_o, 1'b1);
        wb_rst_i = 1; wbs_stb_i = 0; wbs_cyc_i = 0;
        @(negedge wb_clk_i);
        model_reset();
        chk_all_zero("rst_in_ack");
        // write presented in the reset cycle is dropped
        wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = 1; wbs_adr_i = 32'h8;
        wbs_sel_i = 4'hF; wbs_dat_i = 32'h12345678;
        @(negedge wb_clk_i);
        wb_rst_i = 0; wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
        chk("rst_wr_ack", wbs_ack_o, 1'b0);
        xfer(0, 32'h8, 4'hF, 32'h0, 0, rd);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            logic [31:0] adr;
            if ($urandom_range(0, 9) == 0) upd_pulse();
            else begin
                case ($urandom_range(0, 5))
                    0: adr = 32'h0;
                    1: adr = 32'h4;
                    2: adr = 32'h8;
                    3: adr = 32'hC;
                    4: adr = 32'h10 + 4 * $urandom_range(0, 12);
                    default: adr = (ntype_adr(i));
                endcase
                adr = adr | 32'($urandom_range(0, 3));
                xfer(1'($urandom_range(0, 1)), adr, 4'($urandom_range(0, 15)),
                     $urandom, 1'($urandom_range(0, 3) == 0), rd);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    function automatic logic [31:0] ntype_adr(input int i);
        return (i % 2 == 0) ? 32'h0 : 32'h8 + 4 * 32'($urandom_range(0, NCFG - 1));
    endfunction

endmodule

// File: doc/wfg_core_wishbone_regbank.md
WFG_CORE_WISHBONE_REGBANK -- requirements
Module: wfg_core_wishbone_regbank

Interface
REQ-001 SHALL have parameter BUSW, default 32, meaning Wishbone data and address width in bits (multiple of 8).
REQ-002 SHALL have parameter NCFG, default 2, meaning number of shadowed config registers (1..8).
REQ-003 SHALL have port wb_clk_i  input  1  the single clock.
REQ-004 SHALL have port wb_rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports wbs_stb_i, wbs_cyc_i, wbs_we_i  input  1 each  Wishbone strobe, cycle and write-enable.
REQ-006 SHALL have port wbs_sel_i  input  BUSW/8  byte-lane select.
REQ-007 SHALL have ports wbs_dat_i  input  BUSW  write data; wbs_adr_i  input  BUSW  byte address.
REQ-008 SHALL have ports wbs_ack_o  output  1  acknowledge; wbs_dat_o  output  BUSW  registered read data.
REQ-009 SHALL have port update_i  input  1  core sync pulse; commit point for shadowed config.
REQ-010 SHALL have port ctrl_en_q_o  output  1  CTRL.EN.
REQ-011 SHALL have port cfg_q_o  output  NCFG x BUSW  active (committed) config registers.
REQ-012 SHALL have port irq_o  output  1  level interrupt: STATUS.ERR AND CTRL.IRQEN.

Function
REQ-013 Map SHALL be: 0x0 CTRL (bit0 EN, bit1 COMMIT, bit2 IRQEN); 0x4 STATUS (bit0 PEND RO, bit1 ERR W1C); 0x8+4k CFG_SHADOW[k], k<NCFG; bits [1:0] of wbs_adr_i ignored.
REQ-014 Access SHALL be accepted when stb&cyc&!ack; wbs_ack_o SHALL pulse high exactly one cycle, the cycle after acceptance; a held strobe yields one ack per two cycles.
REQ-015 Write side effects and wbs_dat_o SHALL be registered on the acceptance edge; wbs_dat_o SHALL be 0 on writes and when no ack.
REQ-016 Writes SHALL update only byte lanes with wbs_sel_i set; sel all-zero writes nothing and still acks.
REQ-017 Reads SHALL return CFG_SHADOW (not active) values; CTRL.COMMIT always reads 0.
REQ-018 Unmapped address access SHALL ack, read data 0, set STATUS.ERR; no register changes.
REQ-019 Writing 1 to STATUS.ERR (lane 0 selected) SHALL clear it; if a clearing write and an error occur together, error SHALL win (ERR stays 1).
REQ-020 Writing CTRL.COMMIT=1 SHALL set PEND; while PEND, on update_i high, cfg_q_o <= shadow and PEND clears in same cycle.
REQ-021 COMMIT write coincident with update_i SHALL only set PEND (commit at next update_i); update_i without PEND SHALL do nothing.
REQ-022 Shadow writes while PEND SHALL be permitted; commit copies shadow contents at the update_i edge.
REQ-023 CTRL.EN and CTRL.IRQEN SHALL take effect immediately (not shadowed).
REQ-024 Block SHALL run an FSM IDLE -> ACK -> IDLE; ACK state drives wbs_ack_o; cyc dropping in ACK SHALL still return to IDLE next cycle.

Reset
REQ-025 On wb_rst_i SHALL clear: all shadow and active CFG, CTRL, PEND, ERR, wbs_ack_o, wbs_dat_o, FSM to IDLE; irq_o 0.
REQ-026 Reset mid-access SHALL drop pending ack; no write from that cycle takes effect.

Structure
REQ-027 Package wfg_core_regbank_pkg SHALL hold address offsets, CTRL/STATUS bit indices and the FSM state enum.
REQ-028 One sub-module wfg_core_regbank_bytewr SHALL implement byte-lane masked write of one BUSW word; instantiated per register.

Verification
REQ-029 Write 0x00123456 sel=0xF to 0x8 -> single ack pulse; read 0x8 returns 0x00123456; cfg_q_o[0] stays 0.
REQ-030 Write 0xAABBCCDD sel=0x5 to 0xC (was 0) -> reads 0x00BB00DD.
REQ-031 Write CTRL=0x2, then update_i pulse -> STATUS reads 0x1 before, cfg_q_o equals shadow and STATUS 0x0 after.
REQ-032 Read 0x40 with IRQEN=1 -> data 0, ack, ERR=1, irq_o=1; write 0x2 to 0x4 -> ERR=0, irq_o=0.
REQ-033 stb held high for 6 cycles -> exactly 3 ack pulses; wb_rst_i in ACK cycle -> ack low next cycle, all outputs 0.
